// File: rtl/l1602a_nibble_writer_if.sv
// ---------------------------------------------------------------------------
// l1602a_nibble_writer_if
// Groups the byte-request handshake and the LCD 4-bit bus of the
// 1602A nibble writer.
//   cmd_valid/cmd_ready  request handshake (accept when both high)
//   cmd_rs               0 = instruction, 1 = data
//   cmd_data[7:0]        byte to send
//   cmd_long             use the long execution wait (clear/home)
//   cmd_nib              send the high nibble only
//   done                 one-cycle pulse in the last cycle of the wait
//   lcd_ctrl[2:0]        {RS, RW, E}
//   lcd_data[3:0]        DB7..DB4
// master: request source / bus observer; slave: the nibble writer.
// ---------------------------------------------------------------------------
interface l1602a_nibble_writer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       cmd_long;
    logic       cmd_nib;
    logic       done;
    logic [2:0] lcd_ctrl;
    logic [3:0] lcd_data;

    modport master (
        output cmd_valid, cmd_rs, cmd_data, cmd_long, cmd_nib,
        input  cmd_ready, done, lcd_ctrl, lcd_data
    );

    modport slave (
        input  cmd_valid, cmd_rs, cmd_data, cmd_long, cmd_nib,
        output cmd_ready, done, lcd_ctrl, lcd_data
    );
endinterface

// File: rtl/l1602a_nibble_writer.sv
// ---------------------------------------------------------------------------
// l1602a_nibble_writer
// Takes one command/data byte per handshake and drives an HD44780-style
// 4-bit bus: high nibble with its own E strobe, gap, low nibble with its
// own E strobe, then the execution wait before accepting the next byte.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   slave side of l1602a_nibble_writer_if (handshake + LCD bus)
// All outputs are registered. RW is tied low (busy flag never read).
// ---------------------------------------------------------------------------
module l1602a_nibble_writer #(
    parameter int unsigned T_AS   = 1,
    parameter int unsigned T_EPW  = 6,
    parameter int unsigned T_GAP  = 20,
    parameter int unsigned T_EXEC = 1008,
    parameter int unsigned T_LONG = 39360
) (
    input  logic                    clk,
    input  logic                    rst,
    l1602a_nibble_writer_if.slave   bus
);

    localparam logic [19:0] C_AS   = 20'(T_AS);
    localparam logic [19:0] C_EPW  = 20'(T_EPW);
    localparam logic [19:0] C_GAP  = 20'(T_GAP);
    localparam logic [19:0] C_EXEC = 20'(T_EXEC);
    localparam logic [19:0] C_LONG = 20'(T_LONG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_H,
        S_EH_H,
        S_GAP,
        S_SET_L,
        S_EH_L,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q,   cnt_d;
    logic [3:0]  lo_q,    lo_d;     // low nibble kept for the second strobe
    logic        long_q,  long_d;
    logic        nib_q,   nib_d;

    logic        ready_q, ready_d;
    logic        done_q,  done_d;
    logic        e_q,     e_d;
    logic        rs_q,    rs_d;
    logic [3:0]  data_q,  data_d;

    logic        last;
    logic [19:0] wait_len;

    assign last     = (cnt_q == 20'd1);
    assign wait_len = long_q ? C_LONG : C_EXEC;

    // Next state / counter. Every state lasts exactly its reload value:
    // the counter is loaded on entry and the state exits when it reads 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        long_d  = long_q;
        nib_d   = nib_q;
        rs_d    = rs_q;
        data_d  = data_q;

        if (state_q != S_IDLE && !last) begin
            cnt_d = cnt_q - 20'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = S_SET_H;
                    cnt_d   = C_AS;
                    lo_d    = bus.cmd_data[3:0];
                    long_d  = bus.cmd_long;
                    nib_d   = bus.cmd_nib;
                    rs_d    = bus.cmd_rs;
                    data_d  = bus.cmd_data[7:4];
                end
            end
            S_SET_H: begin
                if (last) begin
                    state_d = S_EH_H;
                    cnt_d   = C_EPW;
                end
            end
            S_EH_H: begin
                if (last) begin
                    if (nib_q) begin
                        state_d = S_WAIT;
                        cnt_d   = wait_len;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = C_GAP;
                    end
                end
            end
            S_GAP: begin
                if (last) begin
                    state_d = S_SET_L;
                    cnt_d   = C_AS;
                    data_d  = lo_q;
                end
            end
            S_SET_L: begin
                if (last) begin
                    state_d = S_EH_L;
                    cnt_d   = C_EPW;
                end
            end
            S_EH_L: begin
                if (last) begin
                    state_d = S_WAIT;
                    cnt_d   = wait_len;
                end
            end
            S_WAIT: begin
                if (last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they change
    // in the same cycle the state does.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        e_d     = (state_d == S_EH_H) || (state_d == S_EH_L);
        done_d  = (state_d == S_WAIT) && (cnt_d == 20'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            long_q  <= 1'b0;
            nib_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            long_q  <= long_d;
            nib_q   <= nib_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.lcd_ctrl  = {rs_q, 1'b0, e_q};
    assign bus.lcd_data  = data_q;

endmodule
